// File: rtl/fib_dpram_writer.sv
// rtl/fib_dpram_writer.sv - Fibonacci sequence writer into a dual-port RAM port
//
// Writes NTERMS Fibonacci terms (t0=SEED0, t1=SEED1, tk=t(k-1)+t(k-2) mod 2^16)
// to word addresses BASE_ADDR, BASE_ADDR+2, ... (8-bit wrapping), one per cycle.
// Optional readback (macro FIB_VERIFY_EN): polls BASE_ADDR until the last term
// appears there, then sweeps all words expecting them in reverse order.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, honoured only in IDLE
//   addr      out  [7:0]  RAM address
//   d_out     out  [15:0] RAM write data
//   d_in      in   [15:0] RAM read data, zero-latency
//   wr, rd    out  write / read strobes (never both high)
//   busy      out  run in progress (low during the done cycle)
//   done      out  one-cycle completion pulse
//   err       out  sticky readback/timeout error (0 without FIB_VERIFY_EN)
//   overflow  out  sticky: a term sum carried out of 16 bits

module fib_dpram_writer #(
    parameter int          NTERMS    = 6,
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter logic [15:0] SEED0     = 16'd1,
    parameter logic [15:0] SEED1     = 16'd2,
    parameter logic [15:0] POLL_MAX  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  addr,
    output logic [15:0] d_out,
    input  logic [15:0] d_in,
    output logic        wr,
    output logic        rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_VERIFY,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_K = 4'(NTERMS - 1);

    state_t      state_q;
    logic [7:0]  addr_q;
    logic [15:0] d_out_q;
    logic [15:0] nxt_q;      // term following the one currently on d_out
    logic [3:0]  k_q;
    logic        wr_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;

    // d_out_q holds t(k), nxt_q holds t(k+1): their sum is t(k+2)
    logic [16:0] sum_d;
    logic        sum_used_d;
    assign sum_d      = {1'b0, d_out_q} + {1'b0, nxt_q};
    // the look-ahead sum may run past the last term; its carry must not count
    assign sum_used_d = (int'(k_q) + 2) < NTERMS;

`ifdef FIB_VERIFY_EN
    logic [15:0] terms_q [16];
    logic        rd_q;
    logic        err_q;
    logic [15:0] poll_q;
    logic [15:0] exp_d;
    // the sweep expects the words in reverse order
    assign exp_d = terms_q[LAST_K - k_q];
`else
    logic unused_inputs;
    assign unused_inputs = ^{d_in, POLL_MAX};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            d_out_q <= '0;
            nxt_q   <= '0;
            k_q     <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef FIB_VERIFY_EN
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            poll_q  <= '0;
            for (int i = 0; i < 16; i++) terms_q[i] <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_WRITE;
                        addr_q  <= BASE_ADDR;
                        d_out_q <= SEED0;
                        nxt_q   <= SEED1;
                        k_q     <= '0;
                        wr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
`ifdef FIB_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
`ifdef FIB_VERIFY_EN
                    terms_q[k_q] <= d_out_q;
`endif
                    if (k_q == LAST_K) begin
                        wr_q    <= 1'b0;
                        d_out_q <= '0;
                        addr_q  <= BASE_ADDR;
                        k_q     <= '0;
`ifdef FIB_VERIFY_EN
                        state_q <= S_WAIT;
                        rd_q    <= 1'b1;
                        poll_q  <= '0;
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        k_q     <= k_q + 4'd1;
                        addr_q  <= addr_q + 8'd2;
                        d_out_q <= nxt_q;
                        nxt_q   <= sum_d[15:0];
                        if (sum_d[16] && sum_used_d) ovf_q <= 1'b1;
                    end
                end
`ifdef FIB_VERIFY_EN
                S_WAIT: begin
                    // terms_q[LAST_K] was stored on the final write edge
                    if (d_in == terms_q[LAST_K]) begin
                        state_q <= S_VERIFY;
                        k_q     <= '0;
                        addr_q  <= BASE_ADDR;
                    end else if (poll_q == POLL_MAX - 16'd1) begin
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        poll_q  <= poll_q + 16'd1;
                    end
                end
                S_VERIFY: begin
                    if (d_in != exp_d) err_q <= 1'b1;
                    if (k_q == LAST_K) begin
                        state_q <= S_DONE;
                        k_q     <= '0;
                        addr_q  <= BASE_ADDR;
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        k_q     <= k_q + 4'd1;
                        addr_q  <= addr_q + 8'd2;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr     = addr_q;
    assign d_out    = d_out_q;
    assign wr       = wr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
`ifdef FIB_VERIFY_EN
    assign rd       = rd_q;
    assign err      = err_q;
`else
    assign rd       = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fib_dpram_writer.sv
// tb/tb_fib_dpram_writer.sv - self-checking bench for fib_dpram_writer

module tb_fib_dpram_writer;

    localparam int         NA     = 6;
    localparam int         NB     = 8;
    localparam logic [7:0] BASE_B = 8'hF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] d_out_a, d_out_b, d_in_a, d_in_b;
    logic        wr_a, rd_a, busy_a, done_a, err_a, ovf_a;
    logic        wr_b, rd_b, busy_b, done_b, err_b, ovf_b;

    fib_dpram_writer #(.NTERMS(NA), .BASE_ADDR(8'h00), .SEED0(16'd1), .SEED1(16'd2),
                       .POLL_MAX(16'd16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .addr(addr_a), .d_out(d_out_a),
        .d_in(d_in_a), .wr(wr_a), .rd(rd_a), .busy(busy_a), .done(done_a),
        .err(err_a), .overflow(ovf_a));

    fib_dpram_writer #(.NTERMS(NB), .BASE_ADDR(BASE_B), .SEED0(16'd40000), .SEED1(16'd30000),
                       .POLL_MAX(16'd16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(start_b), .addr(addr_b), .d_out(d_out_b),
        .d_in(d_in_b), .wr(wr_b), .rd(rd_b), .busy(busy_b), .done(done_b),
        .err(err_b), .overflow(ovf_b));

    // RAM models; mode_a selects the consumer behind u_dut:
    // 0 = none, 1 = reverse six words, 2 = reverse then put 0xFFFF at 0x04
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic        clr = 1'b0;
    int          mode_a = 0;
    logic        applied = 1'b0;

    assign d_in_a = mem_a[addr_a];
    assign d_in_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 16'h0;
                mem_b[i] <= 16'h0;
            end
            applied <= 1'b0;
        end else begin
            if (wr_a) mem_a[addr_a] <= d_out_a;
            else if (mode_a != 0 && !applied && mem_a[10] == 16'd13) begin
                for (int i = 0; i < 6; i++) mem_a[2*i] <= mem_a[10-2*i];
                if (mode_a == 2) mem_a[4] <= 16'hFFFF;
                applied <= 1'b1;
            end
            if (wr_b) mem_b[addr_b] <= d_out_b;
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          n;
    } acc_t;

    acc_t wq_a[$], rq_a[$], wq_b[$];
    int   dq_a[$], dq_b[$];
    int   ncnt = 0;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        acc_t e;
        ncnt++;
        if (wr_a) begin e.a = addr_a; e.d = d_out_a; e.n = ncnt; wq_a.push_back(e); end
        if (rd_a) begin e.a = addr_a; e.d = d_in_a;  e.n = ncnt; rq_a.push_back(e); end
        if (wr_b) begin e.a = addr_b; e.d = d_out_b; e.n = ncnt; wq_b.push_back(e); end
        if (done_a) begin
            dq_a.push_back(ncnt);
            checks++;
            if (busy_a !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done_a got %0b want 0", busy_a);
            end
        end
        if (done_b) dq_b.push_back(ncnt);
        checks++;
        if ((wr_a && rd_a) || (wr_b && rd_b)) begin
            errors++;
            $display("FAIL wr_rd_overlap at n=%0d got both high want exclusive", ncnt);
        end
    end

    function automatic logic [15:0] fib_term(input int s0, input int s1, input int k);
        int a = s0;
        int b = s1;
        int c;
        if (k == 0) return 16'(s0);
        for (int i = 1; i < k; i++) begin
            c = (a + b) % 65536;
            a = b;
            b = c;
        end
        return 16'(b);
    endfunction

    function automatic bit fib_ovf(input int s0, input int s1, input int n);
        int a = s0;
        int b = s1;
        int c;
        for (int i = 2; i < n; i++) begin
            if (a + b > 65535) return 1'b1;
            c = (a + b) % 65536;
            a = b;
            b = c;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input bit which, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (which == 1'b0 && dq_a.size() != 0) break;
            if (which == 1'b1 && dq_b.size() != 0) break;
            @(negedge clk); #1;
        end
        checks++;
        if ((which == 1'b0 && dq_a.size() == 0) || (which == 1'b1 && dq_b.size() == 0)) begin
            errors++;
            $display("FAIL done_timeout dut=%0d got no done want done within %0d cycles", which, budget);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk); #1;
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks += 9;
        if (addr_a !== 8'h00)   begin errors++; $display("FAIL rst_addr got %h want 00", addr_a); end
        if (d_out_a !== 16'h0)  begin errors++; $display("FAIL rst_dout got %h want 0", d_out_a); end
        if (wr_a !== 1'b0)      begin errors++; $display("FAIL rst_wr got %b want 0", wr_a); end
        if (rd_a !== 1'b0)      begin errors++; $display("FAIL rst_rd got %b want 0", rd_a); end
        if (busy_a !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy_a); end
        if (done_a !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", done_a); end
        if (err_a !== 1'b0)     begin errors++; $display("FAIL rst_err got %b want 0", err_a); end
        if (ovf_a !== 1'b0)     begin errors++; $display("FAIL rst_ovf got %b want 0", ovf_a); end
        if (addr_b !== BASE_B)  begin errors++; $display("FAIL rst_addr_b got %h want %h", addr_b, BASE_B); end
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_run(input int mode, input bit extra);
        int s;
        int width;
        int base;
        clear_mem();
        mode_a = mode;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        #1;
        wq_a.delete(); rq_a.delete(); dq_a.delete();
        start_a = 1'b1;
        s = ncnt;
        width = $urandom_range(1, 3);
        @(negedge clk); #1;
        checks += 3;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL run_busy_first got %b want 1", busy_a); end
        if (err_a !== 1'b0)  begin errors++; $display("FAIL run_err_cleared got %b want 0", err_a); end
        if (ovf_a !== 1'b0)  begin errors++; $display("FAIL run_ovf_cleared got %b want 0", ovf_a); end
        repeat (width - 1) @(negedge clk);
        #1;
        start_a = 1'b0;
        if (extra) begin
            repeat ($urandom_range(1, 2)) @(negedge clk);
            #1;
            start_a = 1'b1;
            @(negedge clk); #1;
            start_a = 1'b0;
        end
        wait_done(1'b0, 200);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (wq_a.size() != NA) begin
            errors++;
            $display("FAIL run_write_count mode=%0d got %0d want %0d", mode, wq_a.size(), NA);
        end
        for (int k = 0; k < NA && k < wq_a.size(); k++) begin
            checks++;
            if (wq_a[k].a !== 8'(2*k) || wq_a[k].d !== fib_term(1, 2, k) || wq_a[k].n != s + 1 + k) begin
                errors++;
                $display("FAIL run_write k=%0d got a=%h d=%0d n=%0d want a=%h d=%0d n=%0d", k,
                         wq_a[k].a, wq_a[k].d, wq_a[k].n - s, 8'(2*k), fib_term(1, 2, k), 1 + k);
            end
        end
        checks += 2;
        if (dq_a.size() != 1) begin errors++; $display("FAIL run_done_count got %0d want 1", dq_a.size()); end
        if (ovf_a !== fib_ovf(1, 2, NA)) begin errors++; $display("FAIL run_ovf got %b want 0", ovf_a); end
`ifndef FIB_VERIFY_EN
        checks += 2;
        if (dq_a.size() != 0 && dq_a[0] != s + 1 + NA) begin
            errors++;
            $display("FAIL run_done_time got %0d want %0d", dq_a[0] - s, 1 + NA);
        end
        if (rq_a.size() != 0) begin errors++; $display("FAIL run_no_reads got %0d want 0", rq_a.size()); end
`else
        checks++;
        if (err_a !== (mode != 1)) begin
            errors++;
            $display("FAIL run_err mode=%0d got %b want %b", mode, err_a, mode != 1);
        end
        if (mode == 0) begin
            checks++;
            if (rq_a.size() == 0 || dq_a.size() == 0 || dq_a[0] - rq_a[0].n != 16 || rq_a[0].n != s + 1 + NA) begin
                errors++;
                $display("FAIL timeout_latency got reads=%0d want done 16 cycles after wait entry at %0d",
                         rq_a.size(), 1 + NA);
            end
        end else begin
            checks++;
            if (rq_a.size() < NA) begin
                errors++;
                $display("FAIL verify_sweep_len got %0d want >= %0d", rq_a.size(), NA);
            end else begin
                base = rq_a.size() - NA;
                for (int k = 0; k < NA; k++) begin
                    checks++;
                    if (rq_a[base+k].a !== 8'(2*k) ||
                        (mode == 1 && rq_a[base+k].d !== fib_term(1, 2, NA - 1 - k))) begin
                        errors++;
                        $display("FAIL verify_read k=%0d got a=%h d=%0d want a=%h d=%0d", k,
                                 rq_a[base+k].a, rq_a[base+k].d, 8'(2*k), fib_term(1, 2, NA - 1 - k));
                    end
                end
            end
        end
`endif
    endtask

    task automatic test_overflow();
        int s;
        wq_b.delete(); dq_b.delete();
        @(negedge clk); #1;
        start_b = 1'b1;
        s = ncnt;
        @(negedge clk); #1;
        start_b = 1'b0;
        wait_done(1'b1, 200);
        #1;
        checks += 3;
        if (wq_b.size() != NB) begin errors++; $display("FAIL ovf_write_count got %0d want %0d", wq_b.size(), NB); end
        if (wq_b.size() > 2 && wq_b[2].d !== 16'd4464) begin
            errors++;
            $display("FAIL ovf_t2 got %0d want 4464", wq_b[2].d);
        end
        if (ovf_b !== fib_ovf(40000, 30000, NB)) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_b); end
        for (int k = 0; k < NB && k < wq_b.size(); k++) begin
            checks++;
            if (wq_b[k].a !== 8'(BASE_B + 8'(2*k)) || wq_b[k].d !== fib_term(40000, 30000, k) ||
                wq_b[k].n != s + 1 + k) begin
                errors++;
                $display("FAIL ovf_write k=%0d got a=%h d=%0d want a=%h d=%0d", k, wq_b[k].a, wq_b[k].d,
                         8'(BASE_B + 8'(2*k)), fib_term(40000, 30000, k));
            end
        end
`ifdef FIB_VERIFY_EN
        checks++;
        if (err_b !== 1'b1) begin errors++; $display("FAIL ovf_timeout_err got %b want 1", err_b); end
`endif
    endtask

    task automatic test_reset_mid_write();
        int s;
        bit hit;
        clear_mem();
        mode_a = 1;
        wq_a.delete(); dq_a.delete();
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (wr_a && addr_a == 8'h06) hit = 1'b1;
            else begin @(negedge clk); #1; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midrst_reach_k3 got no k=3 write want one"); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (wr_a !== 1'b0)     begin errors++; $display("FAIL midrst_wr got %b want 0", wr_a); end
        if (busy_a !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        if (addr_a !== 8'h00)  begin errors++; $display("FAIL midrst_addr got %h want 00", addr_a); end
        repeat (4) @(negedge clk);
        #1;
        checks += 2;
        if (wq_a.size() != 4) begin errors++; $display("FAIL midrst_writes got %0d want 4", wq_a.size()); end
        if (dq_a.size() != 0) begin errors++; $display("FAIL midrst_done got %0d want 0", dq_a.size()); end
        rst_n = 1'b1;
        start_a = 1'b1;
        s = ncnt;
        @(negedge clk); #1;
        start_a = 1'b0;
        checks += 2;
        if (wr_a !== 1'b1 || d_out_a !== 16'd1 || addr_a !== 8'h00) begin
            errors++;
            $display("FAIL first_start_after_rst got wr=%b d=%0d a=%h want wr=1 d=1 a=00", wr_a, d_out_a, addr_a);
        end
        if (ncnt != s + 1) begin errors++; $display("FAIL first_start_time got %0d want 1", ncnt - s); end
        wait_done(1'b0, 200);
    endtask

    initial begin
        test_reset();
        test_run(0, 1'b0);
        test_run(1, 1'b1);
        test_run(2, 1'b0);
        test_run(1, 1'b1);
        test_overflow();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
